// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate-unit self-test sweep.
// Pure declarations; no timing of its own.
// No flow control; consumers use these values combinationally.
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int GATE_W      = 7;
  localparam int GATE_AND    = 0;
  localparam int GATE_OR     = 1;
  localparam int GATE_NOR    = 2;
  localparam int GATE_NOT    = 3;
  localparam int GATE_NAND   = 4;
  localparam int GATE_XNOR   = 5;
  localparam int GATE_XOR    = 6;
  localparam int NUM_VECTORS = 4;

  // Golden truth-table row for one (a, b) stimulus; NOT only looks at a.
  function automatic logic [GATE_W-1:0] gate_expected(input logic a, input logic b);
    logic [GATE_W-1:0] e;
    e            = '0;
    e[GATE_AND]  = a & b;
    e[GATE_OR]   = a | b;
    e[GATE_NOR]  = ~(a | b);
    e[GATE_NOT]  = ~a;
    e[GATE_NAND] = ~(a & b);
    e[GATE_XNOR] = ~(a ^ b);
    e[GATE_XOR]  = a ^ b;
    return e;
  endfunction

endpackage

// File: rtl/gate_expect.sv
// Expected gate-unit outputs for the currently driven (a, b) stimulus.
// Purely combinational, zero cycles.
// No flow control; output follows inputs continuously.
module gate_expect
  import gate_sweep_pkg::*;
(
  input  logic              a_i,
  input  logic              b_i,
  output logic [GATE_W-1:0] expected_o
);

  assign expected_o = gate_expected(a_i, b_i);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sequences all four a/b vectors into the gate unit, settles, samples and scores them.
// done pulses NUM_PASSES*4*(SETTLE_CYC+2) edges after the edge that accepts start.
// start is ignored while busy; abort returns to IDLE next edge with results frozen.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_in,
  output logic              a_out,
  output logic              b_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [3:0]        fail_vec
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] PASS_LAST   = 4'(NUM_PASSES - 1);
  localparam logic [1:0] IDX_LAST    = 2'(NUM_VECTORS - 1);

  state_e             state_q;
  logic [1:0]         idx_q;
  logic [3:0]         pass_cnt_q;
  logic [7:0]         settle_q;
  logic               a_q, b_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0]   err_q;
  logic [ERR_W-1:0]   err_d;
  logic [3:0]         fail_q;
  logic [GATE_W-1:0]  exp_vec;
  logic               mismatch;

  // Expected row is derived from the registered stimulus actually on the wire.
  gate_expect u_expect (
    .a_i       (a_q),
    .b_i       (b_q),
    .expected_o(exp_vec)
  );

  // One error per bad vector sample, regardless of how many gate bits are wrong.
  always_comb begin
    mismatch = (gate_in != exp_vec);
    err_d    = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + 1'b1;
  end

  // Sweep FSM with all outputs registered; abort overrides everything outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pass_cnt_q <= '0;
      settle_q   <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE && abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        a_q     <= 1'b0;
        b_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              state_q    <= ST_DRIVE;
              busy_q     <= 1'b1;
              err_q      <= '0;
              fail_q     <= '0;
              pass_q     <= 1'b0;
              idx_q      <= '0;
              pass_cnt_q <= '0;
            end
          end
          ST_DRIVE: begin
            a_q      <= idx_q[0];
            b_q      <= idx_q[1];
            settle_q <= SETTLE_LOAD;
            state_q  <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_q == 8'd0) begin
              state_q <= ST_SAMPLE;
            end else begin
              settle_q <= settle_q - 8'd1;
            end
          end
          ST_SAMPLE: begin
            if (mismatch) begin
              err_q         <= err_d;
              fail_q[idx_q] <= 1'b1;
            end
            if (idx_q != IDX_LAST) begin
              idx_q   <= idx_q + 2'd1;
              state_q <= ST_DRIVE;
            end else if (pass_cnt_q != PASS_LAST) begin
              idx_q      <= '0;
              pass_cnt_q <= pass_cnt_q + 4'd1;
              state_q    <= ST_DRIVE;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            pass_q  <= (err_q == '0);
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances with different parameters share stimulus.
// A timeline model predicts every output each cycle; directed phases pin literal values.
// Gate unit is emulated with per-vector fault masks applied to a golden truth table.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [6:0] mask [4];

  logic a0, b0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [3:0] fv0;
  logic [6:0] gin0;
  logic a1, b1, busy1, done1, pass1;
  logic [1:0] err1;
  logic [3:0] fv1;
  logic [6:0] gin1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden gate unit, bit order [6]xor [5]xnor [4]nand [3]not [2]nor [1]or [0]and.
  function automatic logic [6:0] golden(input logic a, input logic b);
    return {a ^ b, ~(a ^ b), ~(a & b), ~a, ~(a | b), a | b, a & b};
  endfunction

  assign gin0 = golden(a0, b0) ^ mask[{b0, a0}];
  assign gin1 = golden(a1, b1) ^ mask[{b1, a1}];

  gate_sweep_ctrl #(.SETTLE_CYC(4), .NUM_PASSES(1), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_in(gin0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fv0)
  );

  gate_sweep_ctrl #(.SETTLE_CYC(2), .NUM_PASSES(3), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_in(gin1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // Run i: k edges since the accepting edge; each vector takes S+2 edges and
  // is scored at its last edge; done at k==T, back to idle at k==T+1.
  int m_set [2] = '{4, 2};
  int m_np  [2] = '{1, 3};
  int m_max [2] = '{255, 3};
  bit m_run [2];
  int m_k   [2];
  int m_err [2];
  logic [3:0] m_fv [2];
  bit m_pass [2];

  always @(posedge clk or negedge rst_n) begin : model
    int per, tot, v;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] = 0; m_k[i] = 0; m_err[i] = 0; m_fv[i] = 4'b0; m_pass[i] = 0;
      end else if (!m_run[i]) begin
        if (start && !abort) begin
          m_run[i] = 1; m_k[i] = 0; m_err[i] = 0; m_fv[i] = 4'b0; m_pass[i] = 0;
        end
      end else if (abort) begin
        m_run[i] = 0;
      end else begin
        per = m_set[i] + 2;
        tot = m_np[i] * 4 * per;
        m_k[i]++;
        if (m_k[i] <= tot && (m_k[i] % per) == 0) begin
          v = (m_k[i] / per - 1) % 4;
          if (mask[v] != 7'd0) begin
            if (m_err[i] < m_max[i]) m_err[i]++;
            m_fv[i][v] = 1'b1;
          end
        end
        if (m_k[i] == tot + 1) begin
          m_run[i]  = 0;
          m_pass[i] = (m_err[i] == 0);
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(posedge clk) begin : compare
    int per, tot, v;
    logic ea, eb, ed;
    #2;
    for (int i = 0; i < 2; i++) begin
      per = m_set[i] + 2;
      tot = m_np[i] * 4 * per;
      v   = (m_run[i] && m_k[i] >= 1 && m_k[i] <= tot) ? ((m_k[i] - 1) / per) % 4 : 0;
      ea  = v[0];
      eb  = v[1];
      ed  = m_run[i] && (m_k[i] == tot);
      chk($sformatf("busy[%0d]", i), (i == 0) ? busy0 : busy1, m_run[i]);
      chk($sformatf("done[%0d]", i), (i == 0) ? done0 : done1, ed);
      chk($sformatf("a_out[%0d]", i), (i == 0) ? a0 : a1, ea);
      chk($sformatf("b_out[%0d]", i), (i == 0) ? b0 : b1, eb);
      chk($sformatf("err_count[%0d]", i), (i == 0) ? 32'(err0) : 32'(err1), m_err[i]);
      chk($sformatf("fail_vec[%0d]", i), (i == 0) ? fv0 : fv1, m_fv[i]);
      chk($sformatf("pass[%0d]", i), (i == 0) ? pass0 : pass1, m_pass[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(output int t0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int inst, input int t0, input int bound, output int rel);
    rel = -1;
    for (int n = 0; n < bound; n++) begin
      @(posedge clk);
      #1;
      if ((inst == 0) ? done0 : done1) begin
        rel = cyc - t0;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (!busy0 && !busy1) begin
        ok = 1;
        break;
      end
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic set_mask(input logic [6:0] m0, input logic [6:0] m1,
                          input logic [6:0] m2, input logic [6:0] m3);
    mask[0] = m0; mask[1] = m1; mask[2] = m2; mask[3] = m3;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int t0, rel;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_mask(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_ab", {a0, b0}, 0);
    chk("rst_err", err0, 0);
    chk("rst_fv", fv0, 0);
    chk("rst_pass_done", {pass0, done0}, 0);
    rst_n = 1'b1;

    // Golden sweep: done 24 edges after start, clean result.
    pulse_start(t0);
    wait_done(0, t0, 100, rel);
    chk("done_edge_golden", rel, 24);
    wait_idle(100);
    chk("golden_pass0", pass0, 1);
    chk("golden_err0", err0, 0);
    chk("golden_fv0", fv0, 0);
    chk("golden_pass1", pass1, 1);

    // xor stuck-at-0: wrong only where a^b==1.
    set_mask(7'h00, 7'h40, 7'h40, 7'h00);
    pulse_start(t0);
    wait_done(1, t0, 200, rel);
    chk("done_edge_3pass", rel, 48);
    wait_idle(100);
    chk("xor_err0", err0, 2);
    chk("xor_fv0", fv0, 4'b0110);
    chk("xor_pass0", pass0, 0);
    chk("xor_err1_sat", err1, 3);
    chk("xor_fv1", fv1, 4'b0110);

    // and stuck-at-1: three bad vectors per pass, saturation on the 2-bit counter.
    set_mask(7'h01, 7'h01, 7'h01, 7'h00);
    pulse_start(t0);
    wait_idle(200);
    chk("and_err0", err0, 3);
    chk("and_fv0", fv0, 4'b0111);
    chk("and_err1_sat", err1, 3);
    chk("and_fv1", fv1, 4'b0111);
    chk("and_pass1", pass1, 0);

    // Extra start during SETTLE of vector 2 is ignored.
    set_mask(0, 0, 0, 0);
    pulse_start(t0);
    repeat (14) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(0, t0, 100, rel);
    chk("done_edge_restart", rel, 24);
    wait_idle(100);
    chk("restart_err0", err0, 0);

    // Abort in SAMPLE of vector 1, with vector 0 faulty.
    set_mask(7'h08, 0, 0, 0);
    pulse_start(t0);
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy0", busy0, 0);
    chk("abort_ab0", {a0, b0}, 0);
    chk("abort_err0_frozen", err0, 1);
    chk("abort_fv0_frozen", fv0, 4'b0001);
    repeat (30) @(negedge clk);
    set_mask(0, 0, 0, 0);
    pulse_start(t0);
    wait_idle(200);
    chk("post_abort_pass0", pass0, 1);
    chk("post_abort_pass1", pass1, 1);

    // Asynchronous reset while vector 1 (a=1) is settling.
    pulse_start(t0);
    repeat (9) @(negedge clk);
    chk("pre_rst_a0", a0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {busy0, busy1}, 0);
    chk("async_rst_a0", a0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (60) @(negedge clk);
    pulse_start(t0);
    wait_idle(200);
    chk("post_rst_pass0", pass0, 1);
    chk("post_rst_pass1", pass1, 1);

    // Randomized traffic: starts, aborts and changing faults, checked by the model.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 40) == 0) begin
        for (int v = 0; v < 4; v++)
          mask[v] = ($urandom_range(0, 1) == 1) ? 7'd0 : 7'($urandom_range(1, 127));
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    wait_idle(200);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
